router_pkt_tx: RTL

Packet source for the 1X3 router input port. The block buffers payload bytes written by a host and, on request, serialises one packet onto the router's byte-wide input: header (length + destination), payload, then a trailing XOR parity byte. Pacing follows the router's `busy` flow control. The block is the transmitter counterpart to the router's receive-side register/parity stage and is used both as a bench driver and as an on-chip traffic source.

---
 rtl/router_pkt_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Buffered packet source for the 1x3 router input port. It sends a
//            header, the payload, then an XOR parity byte, and follows the
//            router's busy flow control.
// Options  : ROUTER_TX_ERR_INJ_EN adds inj_err, which corrupts the sent parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_pkt_tx #(
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic [1:0]               dest,
    input  logic [5:0]               length,
    input  logic                     busy,
`ifdef ROUTER_TX_ERR_INJ_EN
    input  logic                     inj_err,
`endif
    output logic                     pkt_valid,
    output logic [7:0]               data_out,
    output logic                     tx_active,
    output logic                     done,
    output logic                     cfg_err,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     buf_full
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_dout, w_dout_nxt;
    logic            r_pv, w_pv_nxt;
    logic [5:0]      r_rem, w_rem_nxt;
    logic [7:0]      r_par, w_par_nxt;
    logic            r_done, r_active, r_cfg_err, w_cfg_err_nxt;
    logic            w_full, w_push, w_pop, w_accept;
    logic [7:0]      w_rd_data, w_par_out;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_push    = wr_en && !w_full;
    assign w_rd_data = r_mem[r_rd_ptr];
    assign w_accept  = (dest != 2'd3) && (length != 6'd0) && (r_count >= (AW+1)'(length));

`ifdef ROUTER_TX_ERR_INJ_EN
    logic r_inj, w_inj_nxt;
    // Only the transmitted copy is corrupted; the accumulator stays true.
    assign w_par_out = r_par ^ {7'd0, r_inj};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_inj <= 1'b0;
        else       r_inj <= w_inj_nxt;
    end

    always_comb begin
        w_inj_nxt = r_inj;
        if (r_state == S_IDLE && start && w_accept)
            w_inj_nxt = inj_err;
    end
`else
    assign w_par_out = r_par;
`endif

    // Payload memory carries no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dout_nxt    = r_dout;
        w_pv_nxt      = r_pv;
        w_rem_nxt     = r_rem;
        w_par_nxt     = r_par;
        w_pop         = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_accept) begin
                        w_state_nxt = S_HEADER;
                        w_dout_nxt  = {length, dest};
                        w_pv_nxt    = 1'b1;
                        w_rem_nxt   = length;
                        w_par_nxt   = {length, dest};
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (!busy) begin
                    if (r_state == S_HEADER || r_rem != 6'd0) begin
                        w_state_nxt = S_PAYLOAD;
                        w_pop       = 1'b1;
                        w_dout_nxt  = w_rd_data;
                        w_par_nxt   = r_par ^ w_rd_data;
                        w_rem_nxt   = r_rem - 6'd1;
                    end else begin
                        w_state_nxt = S_PARITY;
                        w_dout_nxt  = w_par_out;
                        w_pv_nxt    = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    w_state_nxt = S_DONE;
                    w_dout_nxt  = 8'd0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dout_nxt  = 8'd0;
                w_pv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout    <= 8'd0;
            r_pv      <= 1'b0;
            r_rem     <= 6'd0;
            r_par     <= 8'd0;
            r_done    <= 1'b0;
            r_active  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_dout    <= w_dout_nxt;
            r_pv      <= w_pv_nxt;
            r_rem     <= w_rem_nxt;
            r_par     <= w_par_nxt;
            r_done    <= (w_state_nxt == S_DONE);
            r_active  <= (w_state_nxt != S_IDLE);
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign pkt_valid = r_pv;
    assign data_out  = r_dout;
    assign tx_active = r_active;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign buf_count = r_count;
    assign buf_full  = w_full;

endmodule

`default_nettype wire
